// File: rtl/led_range_counter.sv
// LED range counter: steps counter_out from a latched start toward a latched end in wrap,
// one-shot or bounce mode at a prescaled rate. Optional terminal-event counter: LED_RANGE_COUNTER_EVTCNT_EN.
module led_range_counter #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] start_num,
  input  logic [WIDTH-1:0] end_num,
  input  logic             up_down,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] counter_out,
  output logic             check,
  output logic             busy
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
  ,
  output logic [7:0]       evt_cnt
`endif
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_BOUNCE  = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             dir_q, dir_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             check_q, check_d;
  logic             busy_q;
  logic [WIDTH-1:0] cfg_start_q, cfg_start_d;
  logic [WIDTH-1:0] cfg_end_q, cfg_end_d;
  logic             cfg_up_q, cfg_up_d;
  logic [1:0]       cfg_mode_q, cfg_mode_d;
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
  logic [7:0]       evt_q, evt_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      target_q    <= '0;
      dir_q       <= 1'b0;
      presc_q     <= '0;
      check_q     <= 1'b0;
      busy_q      <= 1'b0;
      cfg_start_q <= '0;
      cfg_end_q   <= '0;
      cfg_up_q    <= 1'b0;
      cfg_mode_q  <= '0;
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
      evt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      target_q    <= target_d;
      dir_q       <= dir_d;
      presc_q     <= presc_d;
      check_q     <= check_d;
      busy_q      <= (state_d == RUN);
      cfg_start_q <= cfg_start_d;
      cfg_end_q   <= cfg_end_d;
      cfg_up_q    <= cfg_up_d;
      cfg_mode_q  <= cfg_mode_d;
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
      evt_q       <= evt_d;
`endif
    end
  end

  // Next-state: load beats tick; a tick at the target is a terminal event
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    target_d    = target_q;
    dir_d       = dir_q;
    presc_d     = presc_q;
    check_d     = 1'b0;
    cfg_start_d = cfg_start_q;
    cfg_end_d   = cfg_end_q;
    cfg_up_d    = cfg_up_q;
    cfg_mode_d  = cfg_mode_q;
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
    evt_d       = evt_q;
`endif
    if (load) begin
      cfg_start_d = start_num;
      cfg_end_d   = end_num;
      cfg_up_d    = up_down;
      cfg_mode_d  = mode;
      counter_d   = start_num;
      target_d    = end_num;
      dir_d       = up_down;
      presc_d     = '0;
      state_d     = RUN;
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
      evt_d       = '0;
`endif
    end else if (state_q == RUN && enable) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (counter_q != target_q) begin
          counter_d = dir_q ? counter_q + WIDTH'(1) : counter_q - WIDTH'(1);
        end else begin
          check_d = 1'b1;
          case (cfg_mode_q)
            MODE_ONESHOT: state_d = DONE;
            MODE_BOUNCE: begin
              // Heading toward cfg end iff dir matches the loaded direction
              target_d = (dir_q == cfg_up_q) ? cfg_start_q : cfg_end_q;
              dir_d    = ~dir_q;
              if (cfg_start_q != cfg_end_q)
                counter_d = dir_q ? counter_q - WIDTH'(1) : counter_q + WIDTH'(1);
            end
            default: counter_d = cfg_start_q;
          endcase
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
    if (check_d && evt_q != 8'hFF) evt_d = evt_q + 8'd1;
`endif
  end

  assign counter_out = counter_q;
  assign check       = check_q;
  assign busy        = busy_q;
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
  assign evt_cnt     = evt_q;
`endif

endmodule

// File: tb/tb_led_range_counter.sv
// Directed bench for led_range_counter: PRESCALE=1 and PRESCALE=4 instances share stimulus.
module tb_led_range_counter;

  logic       clk = 1'b0;
  logic       rst, load, enable, up_down;
  logic [4:0] start_num, end_num;
  logic [1:0] mode;
  logic [4:0] c1, c4;
  logic       chk1, chk4, busy1, busy4;
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
  logic [7:0] evt1, evt4;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_range_counter #(.WIDTH(5), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .enable(enable),
    .start_num(start_num), .end_num(end_num), .up_down(up_down), .mode(mode),
    .counter_out(c1), .check(chk1), .busy(busy1)
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
    , .evt_cnt(evt1)
`endif
  );

  led_range_counter #(.WIDTH(5), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .enable(enable),
    .start_num(start_num), .end_num(end_num), .up_down(up_down), .mode(mode),
    .counter_out(c4), .check(chk4), .busy(busy4)
`ifdef LED_RANGE_COUNTER_EVTCNT_EN
    , .evt_cnt(evt4)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [4:0] s, input logic [4:0] e, input logic up, input logic [1:0] m);
    start_num = s; end_num = e; up_down = up; mode = m; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    int v_wrap[7]  = '{1, 2, 3, 4, 5, 0, 1};
    int k_wrap[7]  = '{0, 0, 0, 0, 0, 1, 0};
    int v_bnc[7]   = '{2, 3, 2, 1, 2, 3, 2};
    int k_bnc[7]   = '{0, 0, 1, 0, 1, 0, 1};
    int v_dn[4]    = '{0, 31, 30, 1};
    int k_dn[4]    = '{0, 0, 0, 1};

    rst = 1'b1; load = 1'b0; enable = 1'b1; up_down = 1'b0;
    start_num = '0; end_num = '0; mode = '0;
    tick(2);
    chk("reset_cnt", c1, 0);
    chk("reset_busy", busy1, 0);
    chk("reset_check", chk1, 0);
    chk("reset_cnt4", c4, 0);
    rst = 1'b0;
    tick(2);
    chk("idle_hold", c1, 0);

    // Wrap 0..5 up
    do_load(5'd0, 5'd5, 1'b1, 2'd0);
    chk("wrap_first", c1, 0);
    chk("wrap_busy", busy1, 1);
    chk("wrap_first_chk", chk1, 0);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("wrap_val", c1, v_wrap[i]);
      chk("wrap_chk", chk1, k_wrap[i]);
    end

    // One-shot 5 down to 0
    do_load(5'd5, 5'd0, 1'b0, 2'd1);
    chk("os_first", c1, 5);
    for (int i = 4; i >= 0; i--) begin
      tick(1);
      chk("os_val", c1, i);
      chk("os_chk", chk1, 0);
    end
    tick(1);
    chk("os_term_chk", chk1, 1);
    chk("os_term_busy", busy1, 0);
    chk("os_term_val", c1, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("os_hold_val", c1, 0);
      chk("os_hold_chk", chk1, 0);
    end

    // Bounce 1..3
    do_load(5'd1, 5'd3, 1'b1, 2'd2);
    chk("bnc_first", c1, 1);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("bnc_val", c1, v_bnc[i]);
      chk("bnc_chk", chk1, k_bnc[i]);
    end

    // Down through the wrap: 1,0,31,30 then reload
    do_load(5'd1, 5'd30, 1'b0, 2'd0);
    chk("dn_first", c1, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("dn_val", c1, v_dn[i]);
      chk("dn_chk", chk1, k_dn[i]);
    end

    // Prescale 4, wrap 30 -> 1 up, with an enable freeze
    do_load(5'd30, 5'd1, 1'b1, 2'd0);
    chk("p4_first", c4, 30);
    tick(3);
    chk("p4_hold30", c4, 30);
    tick(1);
    chk("p4_31", c4, 31);
    tick(2);
    enable = 1'b0;
    tick(10);
    chk("p4_freeze_val", c4, 31);
    chk("p4_freeze_chk", chk4, 0);
    enable = 1'b1;
    tick(1);
    chk("p4_phase_kept", c4, 31);
    tick(1);
    chk("p4_0", c4, 0);
    tick(3);
    chk("p4_hold0", c4, 0);
    tick(1);
    chk("p4_1", c4, 1);
    chk("p4_1_chk", chk4, 0);
    tick(4);
    chk("p4_term_chk", chk4, 1);
    chk("p4_term_val", c4, 30);
    tick(1);
    chk("p4_chk_pulse", chk4, 0);

    // Mid-run reload, load vs terminal tick, reset mid-run
    do_load(5'd0, 5'd10, 1'b1, 2'd0);
    tick(3);
    chk("mid_at3", c1, 3);
    do_load(5'd7, 5'd9, 1'b1, 2'd0);
    chk("mid_reload", c1, 7);
    chk("mid_reload_chk", chk1, 0);
    tick(2);
    chk("mid_at9", c1, 9);
    do_load(5'd2, 5'd4, 1'b1, 2'd0);
    chk("load_wins_val", c1, 2);
    chk("load_wins_chk", chk1, 0);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_val", c1, 0);
    chk("rst_mid_busy", busy1, 0);
    chk("rst_mid_chk", chk1, 0);
    rst = 1'b0;

    // start == end, one-shot: terminal on first tick
    do_load(5'd6, 5'd6, 1'b1, 2'd1);
    chk("eq_os_first", c1, 6);
    tick(1);
    chk("eq_os_chk", chk1, 1);
    chk("eq_os_busy", busy1, 0);
    chk("eq_os_val", c1, 6);

`ifdef LED_RANGE_COUNTER_EVTCNT_EN
    do_load(5'd0, 5'd0, 1'b1, 2'd0);
    chk("evt_clear", evt1, 0);
    tick(1);
    chk("evt_first", evt1, 1);
    tick(299);
    chk("evt_sat", evt1, 255);
    do_load(5'd0, 5'd0, 1'b1, 2'd0);
    chk("evt_load_clear", evt1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_range_counter.md
Name: led_range_counter

Overview:
- Parametrised successor of the LED counter.
- Steps an LED display value from a start value toward an end value, up or down, at a prescaled rate.
- Three run modes: wrap, one-shot and bounce (ping-pong); `check` pulses on each terminal event.
- Sits between the board control logic (switch/button inputs) and the LED driver; configuration is latched by an explicit `load` pulse.

Parameters:
- WIDTH, 5: width of start_num, end_num and counter_out.
- PRESCALE, 1: clocks per count tick; must be >= 1; 1 = tick every clock.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  single-cycle pulse; latches start_num, end_num, up_down, mode; starts a run.
- enable  input  1  1 = run; 0 = freeze prescaler and counter.
- start_num  input  WIDTH  first value of a run.
- end_num  input  WIDTH  terminal value of a run.
- up_down  input  1  1 = count up, 0 = count down (initial direction).
- mode  input  2  0 = wrap, 1 = one-shot, 2 = bounce, 3 = reserved (treated as wrap).
- counter_out  output  WIDTH  current LED value (registered).
- check  output  1  registered one-cycle pulse per terminal event.
- busy  output  1  1 while in RUN state.

Behaviour:
- Reset (rst=1, priority over everything):
  - counter_out=0, check=0, busy=0, state=IDLE, prescaler=0.
  - Latched config cleared to 0.
- States:
  - IDLE: counter holds; ticks ignored.
  - RUN: counting.
  - DONE: one-shot finished; counter holds end value.
- Load:
  - In any state, load=1 latches start/end/up_down/mode into cfg regs.
  - Next cycle: counter_out=start_num, target=end_num, dir=up_down, prescaler=0, state=RUN, busy=1.
  - Load has priority over a coincident tick.
  - Inputs changing without load are ignored.
- Tick generation:
  - In RUN with enable=1, the prescaler counts 0..PRESCALE-1.
  - A tick occurs on the cycle the prescaler equals PRESCALE-1; it then returns to 0.
  - enable=0 freezes the prescaler and counter; check=0.
- On a tick, if counter_out != target: counter_out steps by ±1 per dir, modulo 2^WIDTH.
  - Up from 31 goes to 0; down from 0 goes to 31 (WIDTH=5).
  - A start/end order opposite to dir therefore runs through the wrap.
- On a tick, if counter_out == target (terminal event), check=1 for exactly one cycle, then:
  - Wrap: counter_out=start (cfg); target, dir unchanged; stay RUN.
  - One-shot: counter_out holds; state=DONE, busy=0.
  - Bounce: swap target between cfg end and cfg start; invert dir; counter_out steps one in the new direction.
    - If cfg start == cfg end: counter_out holds, and check fires on every tick.
- Latency:
  - Value visible 1 clock after load.
  - Each subsequent value is visible PRESCALE clocks after the previous one.
  - Terminal value is displayed for one tick period before check.
- start==end, wrap or one-shot: check on the first tick; wrap reloads the same value.
- DONE is left only via load or rst.
- rst mid-run returns to the reset state in the same edge; load mid-run restarts cleanly with no check.

Optional Feature:
- Macro: LED_RANGE_COUNTER_EVTCNT_EN.
- Defined:
  - Adds output evt_cnt [7:0]: counts terminal events (check pulses).
  - Saturates at 255; cleared to 0 on rst and on load.
  - Updates in the same cycle check asserts.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=5, PRESCALE=1, wrap, start=0, end=5, up=1 -> counter_out 0,1,2,3,4,5,0,1...; check high only on cycles where 5->0.
- One-shot, start=5, end=0, up=0 -> 5,4,3,2,1,0; check one pulse; busy=0; counter holds 0 for 20 clocks.
- Bounce, start=1, end=3, up=1 -> 1,2,3,2,1,2,3...; check at each 3->2 and 1->2 turn.
- PRESCALE=4, wrap, start=30, end=1, up=1 -> value changes every 4 clocks: 30,31,0,1,30; enable=0 for 10 clocks freezes value and prescaler phase.
- Mid-run: load with start=7, end=9 while at 3 -> counter_out=7 next cycle, no check; rst mid-run -> next cycle counter_out=0, busy=0, check=0; load and tick coincident -> load wins.
- With LED_RANGE_COUNTER_EVTCNT_EN: wrap, start=0, end=0, 300 ticks -> evt_cnt saturates at 255; load -> evt_cnt=0.
